// File: rtl/vect_wb_queue.sv
// vect_wb_queue: in-order write-back FIFO feeding the vector register bank write port.
// Define VWB_BYPASS_EN for the zero-latency path from lane to bank when the queue is empty.
module vect_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_dir,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         bank_stall,
    output logic [ADDR_W-1:0]            dir_esc,
    output logic [DATA_W-1:0]            data_esc,
    output logic                         signal_esc,
    output logic [(1<<ADDR_W)-1:0]       busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [ADDR_W-1:0] dir_q [DEPTH];
    logic [ADDR_W-1:0] dir_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [CW-1:0] count_q, count_d;
    logic empty, pop, push, bypass;
    always_comb begin
        empty = count_q == '0;
`ifdef VWB_BYPASS_EN
        bypass = empty && in_valid && !bank_stall && !rst;
`else
        bypass = 1'b0;
`endif
        in_ready = count_q != FULL;
        pop = !empty && !bank_stall && !rst;
        push = in_valid && in_ready && !bypass;
        signal_esc = pop || bypass;
        dir_esc = bypass ? in_dir : empty ? '0 : dir_q[rd_ptr_q];
        data_esc = bypass ? in_data : empty ? '0 : data_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        dir_d = dir_q;
        data_d = data_q;
        if (push) begin
            dir_d[wr_ptr_q] = in_dir;
            data_d[wr_ptr_q] = in_data;
        end
    end
    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        busy_mask = '0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (CW'(off) < count_q) busy_mask[dir_q[i]] = 1'b1;
        end
    end
    assign count = count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
        dir_q <= dir_d;
        data_q <= data_d;
    end
endmodule
